// File: rtl/pic_irq_ctrl_gen2.sv
// pic_irq_ctrl_gen2: clocked 8259A-style interrupt controller with a two-pulse INTA vector handshake.
// Define AUTO_ROTATE_EN to build in rotating priority (CTRL.b2 ROT and the set-lowest-priority command).
module pic_irq_ctrl_gen2 #(
    parameter int unsigned N_IRQ       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned VEC_W       = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_IRQ-1:0]  IR,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic [1:0]        ADDR,
    input  logic [31:0]       DIN,
    output logic [31:0]       DOUT,
    output logic              INT,
    input  logic              INTA,
    output logic [VEC_W-1:0]  VEC,
    output logic              VEC_VALID
);
    localparam int unsigned IDX_W = $clog2(N_IRQ);
`ifdef AUTO_ROTATE_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

    state_t            state, state_d;
    logic [N_IRQ-1:0]  sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0]  ir_s, ir_d, irr, irr_d, isr, isr_d, imr, req, rise, set_one, eoi_clr;
    logic [2:0]        ctrl;
    logic [VEC_W-1:0]  vbase;
    logic [IDX_W-1:0]  lowest, pos, elig_idx, isr_top, ack_idx;
    logic              elig_found, isr_found, ack1, ack2, ack_spur;
    logic              wr_en, rd_en, cmd_wr, nsp_eoi, sp_eoi, set_pri, aeoi_clr;
    logic              unused_bits;

    assign ir_s    = sync_q[SYNC_STAGES-1];
    assign wr_en   = CS & WR;
    assign rd_en   = CS & RD;
    assign cmd_wr  = wr_en && (ADDR == 2'd3);
    assign nsp_eoi = cmd_wr && (DIN[7:6] == 2'b01);
    assign sp_eoi  = cmd_wr && (DIN[7:6] == 2'b11);
    assign set_pri = cmd_wr && (DIN[7:6] == 2'b10);
    assign unused_bits = ^{DIN, vbase[IDX_W-1:0], set_pri};

`ifdef AUTO_ROTATE_EN
    logic [IDX_W-1:0] lowest_q;
    assign lowest = lowest_q;
`else
    assign lowest = '1;
`endif

    // Scan in priority order starting after the lowest-priority line; the first in-service
    // bit met blocks every request behind it (fully nested mode).
    always_comb begin
        req        = irr & ~imr;
        pos        = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        isr_found  = 1'b0;
        isr_top    = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            pos = lowest + IDX_W'(k + 1);
            if (isr[pos] && !isr_found) begin
                isr_found = 1'b1;
                isr_top   = pos;
            end
            if (!isr_found && !elig_found && req[pos]) begin
                elig_found = 1'b1;
                elig_idx   = pos;
            end
        end
    end

    always_comb begin
        state_d = state;
        ack1    = 1'b0;
        ack2    = 1'b0;
        unique case (state)
            IDLE: begin
                if (INTA) begin
                    ack1    = 1'b1;
                    state_d = ACK1;
                end else if (elig_found) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (INTA) begin
                    ack1    = 1'b1;
                    state_d = ACK1;
                end else if (!elig_found) begin
                    state_d = IDLE;
                end
            end
            ACK1: begin
                if (INTA) begin
                    ack2    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign INT      = (state != ACK1) && elig_found;
    assign aeoi_clr = ack2 && ctrl[1] && !ack_spur;

    // EOI clears act on the current ISR before the newly acknowledged bit is merged in.
    always_comb begin
        set_one = '0;
        eoi_clr = '0;
        if (ack1 && elig_found) set_one[elig_idx] = 1'b1;
        if (nsp_eoi && isr_found) eoi_clr[isr_top] = 1'b1;
        if (sp_eoi && ({1'b0, DIN[4:0]} < 6'(N_IRQ))) eoi_clr[DIN[IDX_W-1:0]] = 1'b1;
        if (aeoi_clr) eoi_clr[ack_idx] = 1'b1;
        isr_d = (isr & ~eoi_clr) | set_one;
        rise  = ir_s & ~ir_d;
        irr_d = ctrl[0] ? ir_s : ((irr & ~set_one) | rise);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            ir_d      <= '0;
            state     <= IDLE;
            irr       <= '0;
            isr       <= '0;
            imr       <= '1;
            ctrl      <= '0;
            vbase     <= '0;
            ack_idx   <= '0;
            ack_spur  <= 1'b0;
            DOUT      <= '0;
            VEC       <= '0;
            VEC_VALID <= 1'b0;
        end else begin
            sync_q[0] <= IR;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            ir_d      <= ir_s;
            state     <= state_d;
            irr       <= irr_d;
            isr       <= isr_d;
            VEC_VALID <= ack2;
            if (ack1) begin
                ack_idx  <= elig_found ? elig_idx : '1;
                ack_spur <= !elig_found;
            end
            if (ack2) VEC <= {vbase[VEC_W-1:IDX_W], ack_idx};
            if (wr_en) begin
                case (ADDR)
                    2'd0:    ctrl  <= DIN[2:0] & CTRL_MASK;
                    2'd1:    imr   <= DIN[N_IRQ-1:0];
                    2'd2:    vbase <= DIN[VEC_W-1:0];
                    default: ;
                endcase
            end
            if (rd_en) begin
                case (ADDR)
                    2'd0:    DOUT <= 32'(ctrl);
                    2'd1:    DOUT <= 32'(imr);
                    2'd2:    DOUT <= 32'(irr);
                    default: DOUT <= 32'(isr);
                endcase
            end
        end
    end

`ifdef AUTO_ROTATE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lowest_q <= '1;
        end else if (set_pri) begin
            lowest_q <= DIN[IDX_W-1:0];
        end else if (ctrl[2]) begin
            if (aeoi_clr) lowest_q <= ack_idx;
            else if (nsp_eoi && isr_found) lowest_q <= isr_top;
        end
    end
`endif

endmodule

// File: tb/tb_pic_irq_ctrl_gen2.sv
// Directed self-checking bench for pic_irq_ctrl_gen2 (default parameters).
module tb_pic_irq_ctrl_gen2;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  IR;
    logic        CS, WR, RD, INTA;
    logic [1:0]  ADDR;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        INT;
    logic [7:0]  VEC;
    logic        VEC_VALID;

    int n_chk = 0;
    int n_err = 0;

    pic_irq_ctrl_gen2 #(.N_IRQ(8), .SYNC_STAGES(2), .VEC_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .CS(CS), .WR(WR), .RD(RD), .ADDR(ADDR),
        .DIN(DIN), .DOUT(DOUT), .INT(INT), .INTA(INTA), .VEC(VEC), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        CS = 1'b1; WR = 1'b1; ADDR = a; DIN = d;
        tick();
        CS = 1'b0; WR = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        CS = 1'b1; RD = 1'b1; ADDR = a;
        tick();
        CS = 1'b0; RD = 1'b0;
        chk(name, DOUT, exp);
    endtask

    task automatic inta();
        INTA = 1'b1;
        tick();
        INTA = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; IR = '0; CS = 1'b0; WR = 1'b0; RD = 1'b0; INTA = 1'b0; ADDR = '0; DIN = '0;
        tick(3);
        chk("rst_int", INT, 0);
        chk("rst_vec", VEC, 0);
        chk("rst_vv", VEC_VALID, 0);
        chk("rst_dout", DOUT, 0);
        RST_N = 1'b1;
        tick();
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        rd_chk("rst_imr", 2'd1, 32'hFF);
        rd_chk("rst_irr", 2'd2, 32'h0);
        rd_chk("rst_isr", 2'd3, 32'h0);

        // Edge mode, line 0 masked: lines 3 then 7 served in nested order
        wr(2'd2, 32'h40);
        wr(2'd1, 32'h01);
        IR = 8'h89;
        tick(2);
        chk("lat_int_early", INT, 0);
        tick();
        chk("lat_int", INT, 1);
        rd_chk("e_irr", 2'd2, 32'h89);
        inta();
        chk("e_ack1_int", INT, 0);
        rd_chk("e_isr", 2'd3, 32'h08);
        rd_chk("e_irr_clr", 2'd2, 32'h81);
        inta();
        chk("e_vv", VEC_VALID, 1);
        chk("e_vec3", VEC, 32'h43);
        tick();
        chk("e_vv_pulse", VEC_VALID, 0);
        chk("e_nested_int", INT, 0);
        wr(2'd3, 32'h40);
        chk("e_eoi_int", INT, 1);
        tick();
        inta();
        inta();
        chk("e_vec7", VEC, 32'h47);
        wr(2'd3, 32'h40);
        rd_chk("e_isr_end", 2'd3, 32'h0);
        IR = '0;
        tick(4);

        // Level mode: request withdrawn before INTA gives a spurious vector
        wr(2'd0, 32'h1);
        wr(2'd1, 32'h00);
        tick();
        chk("l_idle_int", INT, 0);
        IR = 8'h01;
        tick(3);
        chk("l_int", INT, 1);
        IR = '0;
        tick(3);
        chk("l_int_drop", INT, 0);
        inta();
        inta();
        chk("l_vv", VEC_VALID, 1);
        chk("l_spur_vec", VEC, 32'h47);
        rd_chk("l_isr", 2'd3, 32'h0);

        // Edge mode: ISR[2] blocks IR[5] until specific EOI 2
        wr(2'd0, 32'h0);
        IR = 8'h04;
        tick(3);
        chk("s_int2", INT, 1);
        tick();
        inta();
        inta();
        chk("s_vec2", VEC, 32'h42);
        rd_chk("s_isr2", 2'd3, 32'h04);
        IR = 8'h24;
        tick(4);
        chk("s_blocked", INT, 0);
        rd_chk("s_irr5", 2'd2, 32'h20);
        wr(2'd3, 32'hC2);
        tick();
        chk("s_int5", INT, 1);
        inta();
        inta();
        chk("s_vec5", VEC, 32'h45);
        wr(2'd3, 32'h40);
        rd_chk("s_isr_end", 2'd3, 32'h0);
        IR = '0;
        tick(4);

        // Auto EOI
        wr(2'd0, 32'h2);
        IR = 8'h02;
        tick(3);
        chk("a_int", INT, 1);
        tick();
        inta();
        rd_chk("a_isr_ack1", 2'd3, 32'h02);
        inta();
        chk("a_vv", VEC_VALID, 1);
        chk("a_vec", VEC, 32'h41);
        tick();
        chk("a_vv_pulse", VEC_VALID, 0);
        rd_chk("a_isr", 2'd3, 32'h0);
        IR = '0;
        tick(4);
        wr(2'd0, 32'h0);

`ifdef AUTO_ROTATE_EN
        // Rotation: two held level requests alternate across EOIs
        wr(2'd0, 32'h5);
        rd_chk("r_ctrl", 2'd0, 32'h5);
        IR = 8'h03;
        tick(3);
        for (int j = 0; j < 4; j++) begin
            tick();
            inta();
            inta();
            chk("r_order", VEC, 32'h40 | (j % 2));
            wr(2'd3, 32'h40);
        end
        wr(2'd3, 32'h87);
        IR = '0;
        tick(4);
        wr(2'd0, 32'h0);
`else
        wr(2'd0, 32'h7);
        rd_chk("f_ctrl_rot0", 2'd0, 32'h3);
        wr(2'd0, 32'h0);
`endif

        // Reset between ACK1 and ACK2
        IR = 8'h08;
        tick(3);
        chk("x_int", INT, 1);
        tick();
        inta();
        rd_chk("x_isr", 2'd3, 32'h08);
        RST_N = 1'b0;
        #1;
        chk("x_int_rst", INT, 0);
        chk("x_vv_rst", VEC_VALID, 0);
        chk("x_dout_rst", DOUT, 0);
        IR = '0;
        tick(2);
        RST_N = 1'b1;
        tick();
        rd_chk("x_imr", 2'd1, 32'hFF);
        rd_chk("x_isr0", 2'd3, 32'h0);
        tick(2);
        chk("x_no_vv", VEC_VALID, 0);
        chk("x_vec0", VEC, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
